// File: rtl/cpu_tick_controller.sv
// ---------------------------------------------------------------------------
// cpu_tick_controller
//
// Generates the one-cycle Tick strobe that gates every state-holding register
// of the single-cycle RISC-V core. Three execution modes come from the board
// buttons: halted, free-running at a programmable rate, and single-step.
//
// Parameters
//   DivBits        width of Divisor and of the internal rate counter
//   DebounceCount  cycles StepBtn must be stable before it is accepted (>=1)
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous, active-high
//   RunReq      in   enter free-run
//   HaltReq     in   stop issuing ticks
//   Breakpoint  in   PC-compare hit, same effect as HaltReq
//   StepBtn     in   raw asynchronous bouncing push-button (1 = pressed)
//   Divisor     in   free-run tick period = Divisor+1 cycles
//   Tick        out  registered one-cycle strobe to the core registers
//   Running     out  1 while in the RUNNING state
//   TickCount   out  ticks issued since reset, wraps silently
// ---------------------------------------------------------------------------
module cpu_tick_controller #(
  parameter int DivBits       = 24,
  parameter int DebounceCount = 50000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               RunReq,
  input  logic               HaltReq,
  input  logic               Breakpoint,
  input  logic               StepBtn,
  input  logic [DivBits-1:0] Divisor,
  output logic               Tick,
  output logic               Running,
  output logic [31:0]        TickCount
);

  localparam int DebW = (DebounceCount < 2) ? 1 : $clog2(DebounceCount + 1);
  // The first two post-reset samples of the synchronizer are reset values,
  // not the button, so arming waits two extra cycles.
  localparam int ArmCount = DebounceCount + 2;
  localparam int ArmW     = $clog2(ArmCount + 1);

  typedef enum logic [1:0] {
    HALTED    = 2'd0,
    RUNNING   = 2'd1,
    STEP_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DivBits-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               running_q;
  logic [31:0]        tick_count_q;

  logic               sync1_q, sync2_q;
  logic               deb_q, deb_prev_q;
  logic [DebW-1:0]    deb_cnt_q;
  logic               armed_q;
  logic [ArmW-1:0]    arm_cnt_q;

  logic               halt_req;
  logic               step_evt;

  assign halt_req = HaltReq | Breakpoint;
  // A debounced press only steps once the button has been seen released after
  // reset, so a press held through reset cannot produce a stray tick.
  assign step_evt = deb_q & ~deb_prev_q & armed_q;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    unique case (state_q)
      HALTED: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (RunReq) begin
          state_d = RUNNING;
          cnt_d   = '0;
        end else if (step_evt) begin
          state_d = STEP_WAIT;
          tick_d  = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (RunReq) begin
          state_d = RUNNING;
          cnt_d   = '0;
        end else if (!deb_q) begin
          state_d = HALTED;
        end
      end
      RUNNING: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (cnt_q >= Divisor) begin
          // >= rather than == so a Divisor lowered below the current count
          // ticks on the next edge instead of wrapping the counter.
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + DivBits'(1);
        end
      end
      default: state_d = HALTED;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= HALTED;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      deb_cnt_q    <= '0;
      armed_q      <= 1'b0;
      arm_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == RUNNING);
      if (tick_d) tick_count_q <= tick_count_q + 32'd1;

      sync1_q    <= StepBtn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;

      // Accept the synced level only after it has disagreed with the
      // debounced level for DebounceCount consecutive cycles.
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DebW'(DebounceCount - 1)) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DebW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end

      if (!armed_q) begin
        if (sync2_q) begin
          arm_cnt_q <= '0;
        end else if (arm_cnt_q == ArmW'(ArmCount - 1)) begin
          armed_q <= 1'b1;
        end else begin
          arm_cnt_q <= arm_cnt_q + ArmW'(1);
        end
      end
    end
  end

  assign Tick      = tick_q;
  assign Running   = running_q;
  assign TickCount = tick_count_q;

endmodule
